// File: rtl/dma_bus_arbiter_pkg.sv
// Shared encodings and address constants for the DMA bus arbiter.
// Included by the top and by the priority picker.
package dma_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_CPU  = 2'd0,
    OWN_HDMA = 2'd1,
    OWN_OAM  = 2'd2
  } owner_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_t;

  localparam logic [15:0] HRAM_LO  = 16'hFF80;
  localparam logic [15:0] HRAM_HI  = 16'hFFFE;
  localparam logic [15:0] OAM_BASE = 16'hFE00;

  function automatic logic is_hram(input logic [15:0] addr);
    return (addr >= HRAM_LO) && (addr <= HRAM_HI);
  endfunction

  // The index is not range-checked; the OAM engine owns that.
  function automatic logic [15:0] oam_target(input logic [7:0] idx);
    return {OAM_BASE[15:8], idx};
  endfunction

endpackage

// File: rtl/dma_bus_arbiter_prio_sel.sv
// Combinational fixed-priority picker between the HDMA and OAM DMA requests.
// hdma_over_oam selects which engine wins when both are asserted.
module dma_prio_sel
  import dma_bus_arbiter_pkg::*;
(
  input  logic   hdma_req,
  input  logic   oam_req,
  input  logic   hdma_over_oam,
  output logic   grant_valid,
  output owner_t grant_owner
);

  // Pick the highest-priority asserted DMA request.
  always_comb begin
    grant_valid = hdma_req | oam_req;
    grant_owner = OWN_CPU;
    if (hdma_req && (hdma_over_oam || !oam_req)) begin
      grant_owner = OWN_HDMA;
    end else if (oam_req) begin
      grant_owner = OWN_OAM;
    end else begin
      grant_owner = OWN_CPU;
    end
  end

endmodule

// File: rtl/dma_bus_arbiter.sv
// Shares the external/VRAM/WRAM bus between the CPU, HDMA and OAM DMA.
// Each DMA byte is an atomic read / latch / write sequence ending in an ack pulse.
module dma_bus_arbiter
  import dma_bus_arbiter_pkg::*;
#(
  parameter int RD_LAT        = 1,
  parameter int HDMA_OVER_OAM = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_stall,
  output logic        hram_sel,
  input  logic        hdma_req,
  input  logic [15:0] hdma_src,
  input  logic [15:0] hdma_dst,
  output logic        hdma_ack,
  input  logic        oam_req,
  input  logic [15:0] oam_src,
  input  logic [7:0]  oam_idx,
  output logic        oam_ack,
  output logic [15:0] bus_addr,
  output logic        bus_rd,
  output logic        bus_wr,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata,
  output logic [1:0]  owner
);

  localparam logic [1:0] RD_LAST = 2'(RD_LAT - 1);
  localparam logic       PRIO_HDMA = (HDMA_OVER_OAM != 0);

  state_t      state_r;
  state_t      state_nxt_s;
  owner_t      owner_r;
  owner_t      grant_owner_s;
  logic        grant_valid_s;
  logic [15:0] src_r;
  logic [15:0] dst_r;
  logic [7:0]  data_r;
  logic [1:0]  cnt_r;

  dma_prio_sel u_prio (
    .hdma_req      (hdma_req),
    .oam_req       (oam_req),
    .hdma_over_oam (PRIO_HDMA),
    .grant_valid   (grant_valid_s),
    .grant_owner   (grant_owner_s)
  );

  // State register plus per-byte owner/address/data latches.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      owner_r <= OWN_CPU;
      src_r   <= 16'h0000;
      dst_r   <= 16'h0000;
      data_r  <= 8'h00;
      cnt_r   <= 2'd0;
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        ST_IDLE: begin
          cnt_r <= 2'd0;
          if (grant_valid_s) begin
            owner_r <= grant_owner_s;
            if (grant_owner_s == OWN_HDMA) begin
              src_r <= hdma_src;
              dst_r <= hdma_dst;
            end else begin
              src_r <= oam_src;
              dst_r <= oam_target(oam_idx);
            end
          end
        end
        ST_RD: begin
          if (cnt_r == RD_LAST) begin
            data_r <= bus_rdata;
          end else begin
            cnt_r <= cnt_r + 2'd1;
          end
        end
        ST_WR:   cnt_r <= 2'd0;
        default: cnt_r <= 2'd0;
      endcase
    end
  end

  // Next-state logic: RD always runs to WR so a started byte cannot be preempted.
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE: state_nxt_s = grant_valid_s ? ST_RD : ST_IDLE;
      ST_RD:   state_nxt_s = (cnt_r == RD_LAST) ? ST_WR : ST_RD;
      ST_WR:   state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Bus drive and ack decode; the CPU only reaches the bus in an uncontested IDLE.
  always_comb begin
    hram_sel  = is_hram(cpu_addr);
    bus_addr  = 16'h0000;
    bus_rd    = 1'b0;
    bus_wr    = 1'b0;
    bus_wdata = 8'h00;
    hdma_ack  = 1'b0;
    oam_ack   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!grant_valid_s && !hram_sel) begin
          bus_addr  = cpu_addr;
          bus_rd    = cpu_rd;
          bus_wr    = cpu_wr;
          bus_wdata = cpu_wdata;
        end else begin
          bus_addr  = 16'h0000;
          bus_rd    = 1'b0;
          bus_wr    = 1'b0;
          bus_wdata = 8'h00;
        end
      end
      ST_RD: begin
        bus_addr = src_r;
        bus_rd   = 1'b1;
      end
      ST_WR: begin
        bus_addr  = dst_r;
        bus_wr    = 1'b1;
        bus_wdata = data_r;
        hdma_ack  = (owner_r == OWN_HDMA);
        oam_ack   = (owner_r == OWN_OAM);
      end
      default: begin
        bus_addr = 16'h0000;
      end
    endcase
  end

  assign cpu_stall = (cpu_rd | cpu_wr) & ~hram_sel &
                     ((state_r != ST_IDLE) | hdma_req | oam_req);
  assign cpu_rdata = bus_rdata;
  assign owner     = (state_r == ST_IDLE) ? OWN_CPU : owner_r;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Directed self-checking bench for dma_bus_arbiter; a second instance with
// OAM priority shares the stimulus so both priority orders are exercised.
module tb_dma_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] cpu_addr;
  logic        cpu_rd, cpu_wr;
  logic [7:0]  cpu_wdata;
  logic        hdma_req, oam_req;
  logic [15:0] hdma_src, hdma_dst, oam_src;
  logic [7:0]  oam_idx;

  logic [7:0]  cpu_rdata, bus_wdata, bus_rdata;
  logic        cpu_stall, hram_sel, hdma_ack, oam_ack, bus_rd, bus_wr;
  logic [15:0] bus_addr;
  logic [1:0]  owner;

  logic [7:0]  cpu_rdata_lo, bus_wdata_lo, bus_rdata_lo;
  logic        cpu_stall_lo, hram_sel_lo, hdma_ack_lo, oam_ack_lo, bus_rd_lo, bus_wr_lo;
  logic [15:0] bus_addr_lo;
  logic [1:0]  owner_lo;

  int checks = 0;
  int failures = 0;

  // Memory model: a read returns the low address byte xor 1A, valid in the same cycle.
  assign bus_rdata    = bus_addr[7:0] ^ 8'h1A;
  assign bus_rdata_lo = bus_addr_lo[7:0] ^ 8'h1A;

  always #5 clk = ~clk;

  dma_bus_arbiter #(.RD_LAT(1), .HDMA_OVER_OAM(1)) u_dut (
    .clk(clk), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .hram_sel(hram_sel),
    .hdma_req(hdma_req), .hdma_src(hdma_src), .hdma_dst(hdma_dst), .hdma_ack(hdma_ack),
    .oam_req(oam_req), .oam_src(oam_src), .oam_idx(oam_idx), .oam_ack(oam_ack),
    .bus_addr(bus_addr), .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .owner(owner)
  );

  dma_bus_arbiter #(.RD_LAT(1), .HDMA_OVER_OAM(0)) u_dut_lo (
    .clk(clk), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata_lo), .cpu_stall(cpu_stall_lo), .hram_sel(hram_sel_lo),
    .hdma_req(hdma_req), .hdma_src(hdma_src), .hdma_dst(hdma_dst), .hdma_ack(hdma_ack_lo),
    .oam_req(oam_req), .oam_src(oam_src), .oam_idx(oam_idx), .oam_ack(oam_ack_lo),
    .bus_addr(bus_addr_lo), .bus_rd(bus_rd_lo), .bus_wr(bus_wr_lo), .bus_wdata(bus_wdata_lo),
    .bus_rdata(bus_rdata_lo), .owner(owner_lo)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int acks, cyc, stall_err, addr_err, data_err, last_ack_cyc;
  logic [15:0] last_addr;

  initial begin
    reset_n = 1'b0; cpu_addr = 16'h0000; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_wdata = 8'h00;
    hdma_req = 1'b0; hdma_src = 16'h0000; hdma_dst = 16'h0000;
    oam_req = 1'b0; oam_src = 16'h0000; oam_idx = 8'h00;
    #12;
    check_eq("rst_bus_addr", 32'(bus_addr), 32'h0000);
    check_eq("rst_bus_rdwr", 32'({bus_rd, bus_wr}), 32'h0);
    check_eq("rst_wdata", 32'(bus_wdata), 32'h00);
    check_eq("rst_owner", 32'(owner), 32'h0);
    check_eq("rst_acks_stall", 32'({hdma_ack, oam_ack, cpu_stall}), 32'h0);
    tick();
    reset_n = 1'b1;

    // CPU only: read, write, HRAM window edges
    cpu_rd = 1'b1; cpu_addr = 16'hC000; #1;
    check_eq("cpu_rd_addr", 32'(bus_addr), 32'hC000);
    check_eq("cpu_rd_strobe", 32'({bus_rd, bus_wr}), 32'h2);
    check_eq("cpu_rd_stall", 32'(cpu_stall), 32'h0);
    check_eq("cpu_rd_owner", 32'(owner), 32'h0);
    check_eq("cpu_rdata_fwd", 32'(cpu_rdata), 32'h1A);
    cpu_rd = 1'b0; cpu_wr = 1'b1; cpu_addr = 16'hA123; cpu_wdata = 8'h77; #1;
    check_eq("cpu_wr_bus", 32'({bus_addr, bus_wr, bus_wdata}), {16'hA123, 1'b1, 8'h77});
    cpu_wr = 1'b0; cpu_rd = 1'b1; cpu_addr = 16'hFF80; #1;
    check_eq("hram_lo_sel", 32'({hram_sel, bus_rd}), 32'h2);
    cpu_addr = 16'hFFFE; #1;
    check_eq("hram_hi_sel", 32'(hram_sel), 32'h1);
    cpu_addr = 16'hFFFF; #1;
    check_eq("ie_not_hram", 32'({hram_sel, bus_rd}), 32'h1);
    cpu_addr = 16'hFF7F; #1;
    check_eq("below_hram", 32'(hram_sel), 32'h0);
    cpu_rd = 1'b0; cpu_addr = 16'h0000;

    // HDMA single byte, req dropped during RD
    tick();
    hdma_req = 1'b1; hdma_src = 16'h2040; hdma_dst = 16'h8200; #1;
    check_eq("hdma_idle_owner", 32'({owner, bus_rd}), 32'h0);
    tick();
    check_eq("hdma_rd_bus", 32'({bus_addr, bus_rd, bus_wr}), {16'h2040, 2'b10});
    check_eq("hdma_rd_owner", 32'(owner), 32'h1);
    check_eq("hdma_rd_noack", 32'(hdma_ack), 32'h0);
    hdma_req = 1'b0; hdma_src = 16'h1111; hdma_dst = 16'h2222;
    tick();
    check_eq("hdma_wr_bus", 32'({bus_addr, bus_wr, bus_wdata}), {16'h8200, 1'b1, 8'h5A});
    check_eq("hdma_ack_pulse", 32'({hdma_ack, oam_ack}), 32'h2);
    tick();
    check_eq("hdma_back_idle", 32'({hdma_ack, owner, bus_wr}), 32'h0);

    // OAM burst of 160 bytes with a stalled CPU read; one HRAM probe mid-burst
    cpu_rd = 1'b1; cpu_addr = 16'hC000;
    oam_req = 1'b1; oam_idx = 8'd0; oam_src = 16'hC100; #1;
    check_eq("oam_idle_stall", 32'(cpu_stall), 32'h1);
    acks = 0; cyc = 0; stall_err = 0; addr_err = 0; data_err = 0; last_ack_cyc = 0;
    last_addr = 16'h0000;
    while (acks < 160 && cyc < 2000) begin
      tick();
      cyc++;
      if (cpu_stall !== 1'b1) stall_err++;
      if (oam_ack === 1'b1) begin
        if (bus_addr !== {8'hFE, oam_idx}) addr_err++;
        if (bus_wdata !== (oam_idx ^ 8'h1A)) data_err++;
        last_addr = bus_addr;
        last_ack_cyc = cyc;
        if (oam_idx == 8'd80) begin
          cpu_addr = 16'hFF90; #1;
          check_eq("hram_probe_sel", 32'({hram_sel, cpu_stall}), 32'h2);
          check_eq("hram_probe_bus", 32'(bus_addr), 32'hFE50);
          cpu_addr = 16'hC000;
        end
        acks++;
        if (acks == 160) begin
          oam_req = 1'b0;
        end else begin
          oam_idx = oam_idx + 8'd1;
          oam_src = oam_src + 16'd1;
        end
      end
    end
    check_eq("oam_ack_count", 32'(acks), 32'd160);
    check_eq("oam_last_addr", 32'(last_addr), 32'hFE9F);
    check_eq("oam_last_cycle", 32'(last_ack_cyc), 32'd479);
    check_eq("oam_stall_err", 32'(stall_err), 32'd0);
    check_eq("oam_addr_err", 32'(addr_err), 32'd0);
    check_eq("oam_data_err", 32'(data_err), 32'd0);
    tick();
    check_eq("cpu_after_burst", 32'({bus_addr, bus_rd, cpu_stall}), {16'hC000, 2'b10});

    // Atomic OAM byte, then priority split between the two instances
    oam_req = 1'b1; oam_idx = 8'd5; oam_src = 16'hC105;
    tick();
    check_eq("atom_oam_rd", 32'({owner, owner_lo}), 32'hA);
    hdma_req = 1'b1; hdma_src = 16'h3011; hdma_dst = 16'h8000;
    tick();
    check_eq("atom_oam_wr", 32'({oam_ack, hdma_ack, bus_addr}), {2'b10, 16'hFE05});
    check_eq("atom_oam_data", 32'(bus_wdata), 32'h1F);
    tick();
    check_eq("both_idle_stall", 32'({cpu_stall, bus_rd, owner}), 32'h8);
    tick();
    check_eq("prio_hdma_wins", 32'({owner, bus_addr}), {2'd1, 16'h3011});
    check_eq("prio_oam_wins", 32'({owner_lo, bus_addr_lo}), {2'd2, 16'hC105});
    hdma_req = 1'b0; oam_req = 1'b0;
    tick();
    check_eq("prio_hdma_wr", 32'({hdma_ack, bus_addr, bus_wdata}), {1'b1, 16'h8000, 8'h0B});
    check_eq("prio_lo_oam_wr", 32'({oam_ack_lo, bus_addr_lo}), {1'b1, 16'hFE05});
    cpu_rd = 1'b0;
    tick();

    // Asynchronous reset in the middle of an HDMA read
    hdma_req = 1'b1; hdma_src = 16'h4000; hdma_dst = 16'h9000;
    tick();
    check_eq("rst_pre_rd", 32'(bus_rd), 32'h1);
    #2 reset_n = 1'b0; #1;
    check_eq("rst_async_rd", 32'({bus_rd, bus_wr, owner}), 32'h0);
    tick();
    check_eq("rst_no_ack", 32'({hdma_ack, oam_ack}), 32'h0);
    tick();
    reset_n = 1'b1;
    tick();
    check_eq("rst_restart_rd", 32'({owner, bus_addr, bus_rd}), {2'd1, 16'h4000, 1'b1});
    hdma_req = 1'b0;
    tick();
    check_eq("rst_restart_wr", 32'({hdma_ack, bus_addr, bus_wdata}), {1'b1, 16'h9000, 8'h1A});
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dma_bus_arbiter.md
Name: dma_bus_arbiter

Overview:
- Owns the shared external/VRAM/WRAM bus and shares it between three requesters: CPU, HDMA/GDMA engine (GBC), and OAM DMA engine (FF46).
- DMA requesters present source/target addresses only. This block sequences each DMA byte as a bus read, a data latch and a bus write, then pulses an ack so the engine advances its counter.
- It stalls the CPU while a DMA owns the bus, except for HRAM accesses, which bypass the bus.

Parameters:
- RD_LAT, 1, cycles from bus_rd assertion to bus_rdata valid (1..3).
- HDMA_OVER_OAM, 1, when 1 HDMA outranks OAM DMA; when 0 the order is reversed.

Ports:
- clk  in  1  8 MHz system clock.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_addr  in  16  CPU address.
- cpu_rd  in  1  CPU read strobe.
- cpu_wr  in  1  CPU write strobe.
- cpu_wdata  in  8  CPU write data.
- cpu_rdata  out  8  bus_rdata forwarded to the CPU.
- cpu_stall  out  1  CPU must hold its access.
- hram_sel  out  1  cpu_addr is in FF80..FFFE; the access goes to the HRAM port, not the bus.
- hdma_req  in  1  HDMA wants one byte moved.
- hdma_src  in  16  HDMA source address.
- hdma_dst  in  16  HDMA target address.
- hdma_ack  out  1  one-cycle pulse: HDMA byte written.
- oam_req  in  1  OAM DMA wants one byte moved.
- oam_src  in  16  OAM DMA source address.
- oam_idx  in  8  OAM index 0..159; target address is FE00+idx.
- oam_ack  out  1  one-cycle pulse: OAM byte written.
- bus_addr  out  16  shared bus address.
- bus_rd  out  1  shared bus read.
- bus_wr  out  1  shared bus write.
- bus_wdata  out  8  shared bus write data.
- bus_rdata  in  8  shared bus read data.
- owner  out  2  current bus owner: 0 CPU, 1 HDMA, 2 OAM.

Behaviour:
- Reset (asynchronous assert, synchronous release) drives:
  - state IDLE, owner 0;
  - bus_rd/bus_wr 0, bus_addr 0000, bus_wdata 00;
  - acks 0, cpu_stall 0, data latch 00.
- States: IDLE, RD (RD_LAT cycles, wait counter), WR (1 cycle).
- IDLE arbitrates every cycle:
  - winner is the highest-priority asserted DMA request (priority per HDMA_OVER_OAM);
  - on a winner, latch owner and the source/target addresses, then go to RD;
  - with no request, owner = 0 and the CPU drives the bus combinationally: bus_addr = cpu_addr, bus_rd = cpu_rd, bus_wr = cpu_wr, bus_wdata = cpu_wdata.
- RD:
  - bus_addr = latched source, bus_rd = 1;
  - after RD_LAT cycles, capture bus_rdata into the latch and go to WR.
- WR:
  - bus_addr = latched target, bus_wr = 1, bus_wdata = latch;
  - in the same cycle pulse the owner's ack;
  - next state IDLE.
- DMA byte cost: RD_LAT + 1 cycles for each byte, plus one IDLE cycle before every byte (re-arbitration happens per byte, never per block).
- A DMA byte is atomic. Once RD is entered, WR always completes for the same owner, even if req drops or a higher-priority req rises. The new req wins at the next IDLE.
- Addresses are latched at the IDLE→RD transition; later changes to src/dst are ignored until the next byte.
- OAM target = {8'hFE, oam_idx}. Any oam_idx ≥ A0 is still written; range checking is the engine's job.
- cpu_stall = (cpu_rd | cpu_wr) & ~hram_sel & (state ≠ IDLE or any DMA req asserted).
  - The CPU is never granted in the same cycle a DMA wins.
- hram_sel is combinational on cpu_addr only. HRAM accesses never stall and never touch bus_*.
- cpu_rdata = bus_rdata.
- Simultaneous hdma_req and oam_req: the higher-priority engine gets consecutive bytes while its req stays high, so the lower one may starve. This is accepted; the GBC does not overlap them in practice.
- A req that deasserts during IDLE before being granted is simply not served.

Decomposition:
- Shared package holds the owner encoding (OWN_CPU = 0, OWN_HDMA = 1, OWN_OAM = 2), the state encoding, and the constants HRAM_LO = FF80, HRAM_HI = FFFE, OAM_BASE = FE00.
- One natural sub-module: dma_prio_sel, the combinational fixed-priority picker with an HDMA_OVER_OAM input.

Test Plan:
1. CPU only: cpu_rd at C000, no DMA reqs → bus_addr = C000, bus_rd = 1, cpu_stall = 0, owner = 0.
2. HDMA single byte (RD_LAT = 1): hdma_req, src 2040, dst 8200, bus_rdata = 5A → RD one cycle at 2040, then WR at 8200 with data 5A; hdma_ack pulses once, 3 cycles from req to ack.
3. OAM burst with oam_req held, idx 0..159 via acks, src C100+idx → 160 acks, last write to FE9F, CPU read at C000 stalls throughout.
4. CPU read at FF90 during OAM burst → hram_sel = 1, cpu_stall = 0, bus_addr still on OAM addresses.
5. Priority/atomic: oam byte in RD when hdma_req rises → OAM WR completes with oam_ack; next byte goes to HDMA. With HDMA_OVER_OAM = 0 and both reqs high in IDLE → OAM wins.
6. reset_n low during RD → bus_rd = 0 immediately (asynchronous), no ack, owner = 0. After release, a pending hdma_req restarts cleanly from IDLE.
